// File: rtl/pc_fetch_ctrl.sv
// Fetch PC generator with an in-order in-flight request queue.
// Each queued entry carries a kill bit so responses issued before a redirect come back stale.
module pc_fetch_ctrl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     INC      = 4,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     req_valid,
  output logic [PC_W-1:0]          req_pc,
  input  logic                     req_ready,
  input  logic                     resp_valid,
  output logic [PC_W-1:0]          resp_pc,
  output logic                     resp_stale,
  output logic [PC_W-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     q_full,
  output logic                     q_empty,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_q_pc [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             r_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_occ;

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = req_valid && req_ready;
  assign w_pop   = resp_valid && !w_empty;

  assign req_valid  = !stall && !redirect_valid && !w_full;
  assign req_pc     = r_pc;
  assign pc_out     = r_pc;
  assign inflight   = r_cnt;
  assign q_full     = w_full;
  assign q_empty    = w_empty;
  assign err        = r_err;
  assign resp_pc    = w_empty ? '0 : r_q_pc[r_rptr];
  assign resp_stale = w_empty ? 1'b0 : (r_kill[r_rptr] || redirect_valid);

  // Slot i is occupied when its distance from the head is below the occupancy count.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off      = AW'(i) - r_rptr;
      w_occ[i] = ({1'b0, off} < r_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (!stall && w_push) begin
      r_pc <= r_pc + PC_W'(INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_q_pc[i] <= '0;
      r_kill <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (redirect_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_occ[i]) r_kill[i] <= 1'b1;
        end
      end
      // A push never coincides with a redirect, so the cleared kill bit cannot be overridden.
      if (w_push) begin
        r_q_pc[r_wptr] <= r_pc;
        r_kill[r_wptr] <= 1'b0;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (resp_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, async reset sequence, and
// randomized traffic against a queue-based reference model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_pc;
  logic        resp_stale;
  logic [31:0] pc_out;
  logic [2:0]  inflight;
  logic        q_full;
  logic        q_empty;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_pc        (resp_pc),
    .resp_stale     (resp_stale),
    .pc_out         (pc_out),
    .inflight       (inflight),
    .q_full         (q_full),
    .q_empty        (q_empty),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        rr;
    logic        rsv;
    logic        e_req_valid;
    logic [31:0] e_pc;
    logic [31:0] e_resp_pc;
    logic        e_stale;
    logic [2:0]  e_inf;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic rv, input logic [31:0] rpc, input logic rr,
                     input logic rsv, input logic e_rqv, input logic [31:0] e_pc,
                     input logic [31:0] e_rpc, input logic e_stale, input logic [2:0] e_inf,
                     input logic e_err);
    vec_t v;
    v = '{st, rv, rpc, rr, rsv, e_rqv, e_pc, e_rpc, e_stale, e_inf, e_err};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_rqv, input logic [31:0] e_pc,
                           input logic [31:0] e_rpc, input logic e_stale, input logic [2:0] e_inf,
                           input logic e_err);
    check({tag, ".req_valid"}, 64'(req_valid), 64'(e_rqv));
    check({tag, ".req_pc"}, 64'(req_pc), 64'(e_pc));
    check({tag, ".pc_out"}, 64'(pc_out), 64'(e_pc));
    check({tag, ".resp_pc"}, 64'(resp_pc), 64'(e_rpc));
    check({tag, ".resp_stale"}, 64'(resp_stale), 64'(e_stale));
    check({tag, ".inflight"}, 64'(inflight), 64'(e_inf));
    check({tag, ".q_full"}, 64'(q_full), 64'(e_inf == 3'd4));
    check({tag, ".q_empty"}, 64'(q_empty), 64'(e_inf == 3'd0));
    check({tag, ".err"}, 64'(err), 64'(e_err));
  endtask

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pcq[$];
  bit          m_kill[$];
  bit          m_err;

  initial begin
    // st rv rpc rr rsv | req_valid pc resp_pc stale inflight err
    add(0, 0, 32'h0,   1, 0,  1, 32'h0,  32'h0,  0, 0, 0);
    add(0, 0, 32'h0,   1, 0,  1, 32'h4,  32'h0,  0, 1, 0);
    add(0, 0, 32'h0,   1, 0,  1, 32'h8,  32'h0,  0, 2, 0);
    add(0, 0, 32'h0,   1, 0,  1, 32'hC,  32'h0,  0, 3, 0);
    add(0, 0, 32'h0,   1, 0,  0, 32'h10, 32'h0,  0, 4, 0);
    add(0, 0, 32'h0,   1, 1,  0, 32'h10, 32'h0,  0, 4, 0);
    add(0, 0, 32'h0,   1, 1,  1, 32'h10, 32'h4,  0, 3, 0);
    add(0, 0, 32'h0,   1, 1,  1, 32'h14, 32'h8,  0, 3, 0);
    add(0, 0, 32'h0,   0, 1,  1, 32'h18, 32'hC,  0, 3, 0);
    add(0, 0, 32'h0,   0, 1,  1, 32'h18, 32'h10, 0, 2, 0);
    add(0, 0, 32'h0,   0, 1,  1, 32'h18, 32'h14, 0, 1, 0);
    add(0, 0, 32'h0,   0, 1,  1, 32'h18, 32'h0,  0, 0, 0);
    add(0, 0, 32'h0,   0, 0,  1, 32'h18, 32'h0,  0, 0, 1);
    add(0, 0, 32'h0,   1, 0,  1, 32'h18, 32'h0,  0, 0, 1);
    add(0, 0, 32'h0,   1, 0,  1, 32'h1C, 32'h18, 0, 1, 1);
    add(0, 1, 32'h100, 1, 0,  0, 32'h20, 32'h18, 1, 2, 1);
    add(0, 0, 32'h0,   0, 1,  1, 32'h100, 32'h18, 1, 2, 1);
    add(0, 0, 32'h0,   1, 1,  1, 32'h100, 32'h1C, 1, 1, 1);
    add(0, 0, 32'h0,   0, 1,  1, 32'h104, 32'h100, 0, 1, 1);
    add(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h104, 32'h0, 0, 0, 1);
    add(0, 0, 32'h0,   1, 0,  1, 32'hFFFF_FFFC, 32'h0, 0, 0, 1);
    add(1, 0, 32'h0,   1, 0,  0, 32'h0,  32'hFFFF_FFFC, 0, 1, 1);
    add(0, 1, 32'h200, 1, 1,  0, 32'h0,  32'hFFFF_FFFC, 1, 1, 1);
    add(0, 0, 32'h0,   0, 0,  1, 32'h200, 32'h0, 0, 0, 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (vq[i]) begin
      @(negedge clk);
      stall          = vq[i].st;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      req_ready      = vq[i].rr;
      resp_valid     = vq[i].rsv;
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_req_valid, vq[i].e_pc, vq[i].e_resp_pc,
                vq[i].e_stale, vq[i].e_inf, vq[i].e_err);
    end

    // Asynchronous reset mid-cycle with two entries in flight and err set
    @(negedge clk);
    stall = 0; redirect_valid = 0; req_ready = 1; resp_valid = 0;
    repeat (2) @(negedge clk);
    req_ready = 0;
    #1;
    check("pre_rst.inflight", 64'(inflight), 64'd2);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b1, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    resp_valid = 1'b0;
    @(negedge clk);
    #1;
    check_all("post_rst", 1'b1, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);

    // Randomized traffic against the reference model, starting from the reset state
    m_pc = 32'h0;
    m_pcq.delete();
    m_kill.delete();
    m_err = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic e_rqv;
      logic push, pop;
      @(negedge clk);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
      req_ready      = $urandom_range(0, 1) == 1;
      resp_valid     = ($urandom_range(0, 99) == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      #1;
      e_rqv = !stall && !redirect_valid && (m_pcq.size() < 4);
      check_all($sformatf("rnd%0d", cyc), e_rqv, m_pc,
                (m_pcq.size() > 0) ? m_pcq[0] : 32'h0,
                (m_pcq.size() > 0) ? (m_kill[0] || redirect_valid) : 1'b0,
                3'(m_pcq.size()), m_err);
      @(posedge clk);
      push = e_rqv && req_ready;
      pop  = resp_valid && (m_pcq.size() > 0);
      if (resp_valid && m_pcq.size() == 0) m_err = 1;
      if (pop) begin
        void'(m_pcq.pop_front());
        void'(m_kill.pop_front());
      end
      if (redirect_valid) begin
        foreach (m_kill[k]) m_kill[k] = 1;
      end
      if (push) begin
        m_pcq.push_back(m_pc);
        m_kill.push_back(0);
      end
      if (redirect_valid) m_pc = redirect_pc;
      else if (push) m_pc = m_pc + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
